mesh_term_tx: RTL and testbench

- Terminal-side ingress stage placed directly upstream of one mesh_gnrtr terminal port; one instance per terminal.
- Accepts destination/mode/payload fields from a producer and assembles them into a pckg_sz-bit packet.
- Buffers packets in a FIFO and presents the head to the router on data_out_i_in/pndng_i_in; the router consumes it with popin.
- Drops self-addressed packets and reports the drop.

---
 rtl/mesh_pkg.sv | 59 +++++
 rtl/mesh_term_tx_if.sv | 27 ++
 rtl/mesh_tx_fifo.sv | 69 ++++++
 rtl/mesh_term_tx.sv | 112 +++++++++++
 tb/tb_mesh_term_tx.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mesh_pkg.sv
// Shared packet-format definitions for the mesh terminal ingress stage.
// Field offsets are functions of the packet width so one package serves every pckg_sz.
package mesh_pkg;

  localparam int NXT_JUMP_W = 8;
  localparam int ID_W       = 4;
  localparam int MODE_W     = 1;
  localparam int HDR_W      = NXT_JUMP_W + 2 * ID_W + MODE_W;
  localparam int PKT_MAX_W  = 256;

  typedef logic [PKT_MAX_W-1:0] pkt_max_t;

  typedef enum logic [MODE_W-1:0] {
    MODE_ROW_FIRST = 1'b0,
    MODE_COL_FIRST = 1'b1
  } route_mode_e;

  function automatic int payload_w(input int pckg_sz);
    return pckg_sz - HDR_W;
  endfunction

  function automatic int mode_off(input int pckg_sz);
    return payload_w(pckg_sz);
  endfunction

  function automatic int col_off(input int pckg_sz);
    return mode_off(pckg_sz) + MODE_W;
  endfunction

  function automatic int row_off(input int pckg_sz);
    return col_off(pckg_sz) + ID_W;
  endfunction

  function automatic int nxt_jump_off(input int pckg_sz);
    return row_off(pckg_sz) + ID_W;
  endfunction

  // Result is PKT_MAX_W wide; callers truncate to their own pckg_sz.
  // Nxt_jump is left at zero because only the router rewrites it.
  function automatic pkt_max_t pack_pkt(input int pckg_sz,
                                        input logic [ID_W-1:0] row,
                                        input logic [ID_W-1:0] col,
                                        input logic [MODE_W-1:0] mode,
                                        input pkt_max_t payload);
    pkt_max_t pkt;
    pkt_max_t mask;
    mask = {PKT_MAX_W{1'b1}} >> (PKT_MAX_W - payload_w(pckg_sz));
    pkt  = payload & mask;
    pkt  = pkt | (pkt_max_t'(mode) << mode_off(pckg_sz));
    pkt  = pkt | (pkt_max_t'(col)  << col_off(pckg_sz));
    pkt  = pkt | (pkt_max_t'(row)  << row_off(pckg_sz));
    return pkt;
  endfunction

  function automatic pkt_max_t bcast_const(input int pckg_sz);
    return {PKT_MAX_W{1'b1}} >> (PKT_MAX_W - (pckg_sz - 18));
  endfunction

endpackage

// File: rtl/mesh_term_tx_if.sv
// Producer-facing and router-facing signals of one mesh terminal ingress port.
interface mesh_term_tx_if #(
  parameter int PCKG_SZ = 40
);
  // Producer side: a request transfers on any rising clk edge where in_valid && in_ready;
  // in_valid and fields must hold until then. Router side: the head transfers on an edge
  // where pndng_i_in && popin; popin with pndng_i_in low is an error, not a transfer.
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_row;
  logic [3:0]         in_col;
  logic               in_mode;
  logic [PCKG_SZ-18:0] in_payload;
  logic [PCKG_SZ-1:0] data_out_i_in;
  logic               pndng_i_in;
  logic               popin;

  modport master (
    output in_valid, in_row, in_col, in_mode, in_payload, popin,
    input  in_ready, data_out_i_in, pndng_i_in
  );

  modport slave (
    input  in_valid, in_row, in_col, in_mode, in_payload, popin,
    output in_ready, data_out_i_in, pndng_i_in
  );
endinterface

// File: rtl/mesh_tx_fifo.sv
// Show-ahead synchronous FIFO; dout holds the last presented head while empty.
module mesh_tx_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q  [DEPTH];
  logic [W-1:0]  mem_d  [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  last_q, last_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign dout    = empty ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    // Remember whatever is on dout so an emptied FIFO keeps showing it.
    if (!empty) last_d = mem_q[rd_ptr_q];
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end
endmodule

// File: rtl/mesh_term_tx.sv
// Terminal ingress stage: packs producer fields into a packet, drops self-addressed ones,
// and queues the rest for the router. Define MESH_TERM_TX_STATS_EN for sent_cnt/max_occ.
module mesh_term_tx
  import mesh_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4,
  parameter int SELF_ROW   = 0,
  parameter int SELF_COL   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  mesh_term_tx_if.slave               bus,
  output logic [$clog2(fifo_depth):0] fifo_count,
  output logic [7:0]                  drop_cnt,
  output logic                        err_underflow
`ifdef MESH_TERM_TX_STATS_EN
  ,
  output logic [15:0]                 sent_cnt,
  output logic [$clog2(fifo_depth):0] max_occ
`endif
);
  localparam int CW = $clog2(fifo_depth) + 1;

  if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0)) begin : g_bad_depth
    $error("mesh_term_tx: fifo_depth must be a power of two, at least 2");
  end
  if ((SELF_ROW > ROWS + 1) || (SELF_COL > COLUMS + 1)) begin : g_bad_self_id
    $error("mesh_term_tx: SELF_ROW/SELF_COL outside the mesh id range");
  end

  logic               full, empty;
  logic               self_hit, accept, push, pop_ok;
  logic [pckg_sz-1:0] pkt;
  logic [7:0]         drop_q, drop_d;
  logic               err_q, err_d;

  // in_ready comes only from the registered occupancy, never from popin.
  assign bus.in_ready = !full;
  assign bus.pndng_i_in = !empty;

  assign self_hit = (bus.in_row == ID_W'(SELF_ROW)) && (bus.in_col == ID_W'(SELF_COL));
  assign accept   = bus.in_valid && bus.in_ready;
  assign push     = accept && !self_hit;
  assign pop_ok   = bus.popin && !empty;
  assign pkt      = pckg_sz'(pack_pkt(pckg_sz, bus.in_row, bus.in_col, bus.in_mode,
                                      pkt_max_t'(bus.in_payload)));

  mesh_tx_fifo #(
    .W     (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (pkt),
    .pop   (bus.popin),
    .dout  (bus.data_out_i_in),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    drop_d = drop_q;
    err_d  = err_q;
    if (accept && self_hit && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    if (bus.popin && empty) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  assign drop_cnt      = drop_q;
  assign err_underflow = err_q;

`ifdef MESH_TERM_TX_STATS_EN
  logic [15:0]   sent_q, sent_d;
  logic [CW-1:0] max_occ_q, max_occ_d;
  logic [CW-1:0] count_nxt;

  // Track the occupancy the FIFO will hold after this edge so the mark never lags.
  assign count_nxt = fifo_count + CW'(push) - CW'(pop_ok);

  always_comb begin
    sent_d    = sent_q + 16'(pop_ok);
    max_occ_d = (count_nxt > max_occ_q) ? count_nxt : max_occ_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sent_q    <= '0;
      max_occ_q <= '0;
    end else begin
      sent_q    <= sent_d;
      max_occ_q <= max_occ_d;
    end
  end

  assign sent_cnt = sent_q;
  assign max_occ  = max_occ_q;
`endif
endmodule

// File: tb/tb_mesh_term_tx.sv
// Bench for mesh_term_tx: directed vector table, hand sequences and a randomized run
// checked against a queue-based model of the terminal ingress behaviour.
module tb_mesh_term_tx;
  localparam int PW    = 40;
  localparam int PLW   = PW - 17;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mesh_term_tx_if #(.PCKG_SZ(PW)) bus ();
  logic [CW-1:0] fifo_count;
  logic [7:0]    drop_cnt;
  logic          err_underflow;
`ifdef MESH_TERM_TX_STATS_EN
  logic [15:0]   sent_cnt;
  logic [CW-1:0] max_occ;
`endif

  mesh_term_tx #(
    .pckg_sz(PW), .fifo_depth(DEPTH), .ROWS(4), .COLUMS(4), .SELF_ROW(0), .SELF_COL(1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .fifo_count    (fifo_count),
    .drop_cnt      (drop_cnt),
    .err_underflow (err_underflow)
`ifdef MESH_TERM_TX_STATS_EN
    ,
    .sent_cnt      (sent_cnt),
    .max_occ       (max_occ)
`endif
  );

  // Reference model state
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] m_last;
  int            m_drop;
  bit            m_err;
  int            m_sent;
  int            m_max;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit             v;
    int             row;
    int             col;
    bit             mode;
    logic [PLW-1:0] pl;
    bit             pop;
    int             e_cnt;
    bit             e_pnd;
    bit             e_rdy;
    logic [PW-1:0]  e_data;
    int             e_drop;
    bit             e_err;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [PW-1:0] pk(input int row, input int col, input bit mode,
                                        input logic [PLW-1:0] pl);
    return {8'h00, 4'(row), 4'(col), mode, pl};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit v, input int row, input int col, input bit mode,
                              input logic [PLW-1:0] pl, input bit pop);
    bit rdy;
    rdy = (exp_q.size() < DEPTH);
    if (exp_q.size() > 0) m_last = exp_q[0];
    if (pop) begin
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        m_sent = (m_sent + 1) % 65536;
      end else begin
        m_err = 1'b1;
      end
    end
    if (v && rdy) begin
      if (row == 0 && col == 1) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      else exp_q.push_back(pk(row, col, mode, pl));
    end
    if (exp_q.size() > m_max) m_max = exp_q.size();
  endtask

  task automatic check_model(input string tag);
    logic [PW-1:0] e_data;
    e_data = (exp_q.size() > 0) ? exp_q[0] : m_last;
    chk({tag, "_count"}, 64'(fifo_count), 64'(exp_q.size()));
    chk({tag, "_pndng"}, 64'(bus.pndng_i_in), 64'(exp_q.size() > 0));
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'(exp_q.size() < DEPTH));
    chk({tag, "_data"}, 64'(bus.data_out_i_in), 64'(e_data));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(m_drop));
    chk({tag, "_err"}, 64'(err_underflow), 64'(m_err));
`ifdef MESH_TERM_TX_STATS_EN
    chk({tag, "_sent"}, 64'(sent_cnt), 64'(m_sent));
    chk({tag, "_maxocc"}, 64'(max_occ), 64'(m_max));
`endif
  endtask

  task automatic step(input bit v, input int row, input int col, input bit mode,
                      input logic [PLW-1:0] pl, input bit pop, input string tag);
    bus.in_valid   = v;
    bus.in_row     = 4'(row);
    bus.in_col     = 4'(col);
    bus.in_mode    = mode;
    bus.in_payload = pl;
    bus.popin      = pop;
    @(posedge clk);
    model_update(v, row, col, mode, pl, pop);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.popin      = 1'b0;
    @(posedge clk);
    exp_q.delete();
    m_last = '0;
    m_drop = 0;
    m_err  = 1'b0;
    m_sent = 0;
    m_max  = 0;
    #1;
    check_model(tag);
    reset = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] p0;
    p0 = 40'h0023812345;
    // v row col mode payload pop | cnt pnd rdy data drop err
    tbl[0]  = '{1, 2, 3, 1, 23'h012345, 0, 1, 1, 1, p0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 23'h0,      1, 0, 0, 1, p0, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 23'h7,      0, 0, 0, 1, p0, 1, 0};
    tbl[3]  = '{1, 2, 2, 0, 23'd1,      0, 1, 1, 1, pk(2, 2, 0, 23'd1), 1, 0};
    tbl[4]  = '{1, 2, 2, 0, 23'd2,      0, 2, 1, 1, pk(2, 2, 0, 23'd1), 1, 0};
    tbl[5]  = '{1, 2, 2, 0, 23'd3,      0, 3, 1, 1, pk(2, 2, 0, 23'd1), 1, 0};
    tbl[6]  = '{1, 2, 2, 0, 23'd4,      0, 4, 1, 0, pk(2, 2, 0, 23'd1), 1, 0};
    tbl[7]  = '{1, 2, 2, 0, 23'd5,      0, 4, 1, 0, pk(2, 2, 0, 23'd1), 1, 0};
    tbl[8]  = '{1, 2, 2, 0, 23'd5,      1, 3, 1, 1, pk(2, 2, 0, 23'd2), 1, 0};
    tbl[9]  = '{1, 2, 2, 0, 23'd5,      0, 4, 1, 0, pk(2, 2, 0, 23'd2), 1, 0};
    tbl[10] = '{0, 0, 0, 0, 23'h0,      1, 3, 1, 1, pk(2, 2, 0, 23'd3), 1, 0};
    tbl[11] = '{0, 0, 0, 0, 23'h0,      1, 2, 1, 1, pk(2, 2, 0, 23'd4), 1, 0};
    tbl[12] = '{1, 2, 2, 0, 23'd6,      1, 2, 1, 1, pk(2, 2, 0, 23'd5), 1, 0};
    tbl[13] = '{0, 0, 0, 0, 23'h0,      1, 1, 1, 1, pk(2, 2, 0, 23'd6), 1, 0};
    tbl[14] = '{0, 0, 0, 0, 23'h0,      1, 0, 0, 1, pk(2, 2, 0, 23'd6), 1, 0};
    tbl[15] = '{0, 0, 0, 0, 23'h0,      1, 0, 0, 1, pk(2, 2, 0, 23'd6), 1, 1};

    bus.in_valid = 1'b0; bus.in_row = '0; bus.in_col = '0;
    bus.in_mode = 1'b0; bus.in_payload = '0; bus.popin = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    do_reset("rst0");
    chk("rst0_data_zero", 64'(bus.data_out_i_in), 64'h0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].row, tbl[i].col, tbl[i].mode, tbl[i].pl, tbl[i].pop,
           $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_vcnt", i), 64'(fifo_count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_vpnd", i), 64'(bus.pndng_i_in), 64'(tbl[i].e_pnd));
      chk($sformatf("tbl%0d_vrdy", i), 64'(bus.in_ready), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_vdata", i), 64'(bus.data_out_i_in), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_vdrop", i), 64'(drop_cnt), 64'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_verr", i), 64'(err_underflow), 64'(tbl[i].e_err));
    end

    // Drop counter saturation
    for (int i = 0; i < 300; i++) step(1, 0, 1, i[0], 23'(i), 0, "self");
    chk("self_sat", 64'(drop_cnt), 64'd255);
    chk("self_empty", 64'(fifo_count), 64'd0);

    // Reset mid-operation discards queued packets and clears the sticky error
    for (int i = 0; i < 3; i++) step(1, 3, 4, 0, 23'(100 + i), 0, "prerst");
    chk("prerst_cnt", 64'(fifo_count), 64'd3);
    do_reset("midrst");
    chk("midrst_pnd", 64'(bus.pndng_i_in), 64'd0);
    chk("midrst_cnt", 64'(fifo_count), 64'd0);
    chk("midrst_err", 64'(err_underflow), 64'd0);

`ifdef MESH_TERM_TX_STATS_EN
    for (int i = 0; i < 4; i++) step(1, 1, 2, 1, 23'(i + 1), 0, "stpush");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 23'h0, 1, "stpop");
    chk("stats_sent", 64'(sent_cnt), 64'd4);
    chk("stats_max", 64'(max_occ), 64'd4);
    do_reset("strst");
`endif

    // Randomized traffic, including illegal ids and occasional resets
    for (int i = 0; i < 600; i++) begin
      bit v, pop, mode;
      int row, col;
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rrst");
      end else begin
        v    = ($urandom_range(0, 99) < 60);
        pop  = ($urandom_range(0, 99) < 45);
        mode = 1'($urandom_range(0, 1));
        row  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 15);
        col  = ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(0, 15);
        step(v, row, col, mode, 23'($urandom), pop, "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
